// File: rtl/lcd_ci_sequencer.sv
// lcd_ci_sequencer: Nios II multi-cycle custom instruction driving an
// HD44780 character LCD over an 8-bit bus (write, data, init, status).
// Ports: clk, reset (async, high), clk_en, start, dataa[7:0]=byte,
//   datab[1:0]=mode (00 cmd, 01 data, 10 init, 11 status), result, done,
//   lcd_enable, lcd_rs, lcd_rw (always 0), lcd_data.
module lcd_ci_sequencer #(
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned EN_PULSE_CYCLES   = 25,
    parameter int unsigned HOLD_CYCLES       = 2,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000,
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter logic [7:0]  INIT_FUNC         = 8'h38,
    parameter logic [7:0]  INIT_DISP         = 8'h0C,
    parameter logic [7:0]  INIT_ENTRY        = 8'h06
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        lcd_enable,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    function automatic int unsigned max2(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXW =
        max2(max2(max2(SETUP_CYCLES, EN_PULSE_CYCLES), max2(HOLD_CYCLES,
        CMD_WAIT_CYCLES)), max2(CLEAR_WAIT_CYCLES, POWERUP_CYCLES));
    localparam int CW = $clog2(MAXW + 1);

    typedef enum logic [2:0] {
        IDLE, PWRUP, SETUP, PULSE, HOLD, WAIT, NEXT, FINISH
    } state_t;

    state_t      r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [1:0]  r_step, w_step_n;
    logic [1:0]  r_mode, w_mode_n;
    logic        r_init, w_init_n;
    logic        r_en, w_en_n;
    logic        r_rs, w_rs_n;
    logic        r_done, w_done_n;
    logic [7:0]  r_data, w_data_n;
    logic [31:0] r_result, w_result_n;
    logic [CW-1:0] w_wait_last;
    logic        w_unused;

    // Terminal count for an N-edge interval (counter starts at 0).
    function automatic logic [CW-1:0] last(input int unsigned n);
        return CW'(n - 1);
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] s);
        case (s)
            2'd0:    return INIT_FUNC;
            2'd1:    return INIT_DISP;
            2'd2:    return 8'h01;
            default: return INIT_ENTRY;
        endcase
    endfunction

    // Clear / return-home commands need the long execution wait.
    assign w_wait_last = (!r_rs && (r_data == 8'h01 || r_data == 8'h02))
                       ? last(CLEAR_WAIT_CYCLES) : last(CMD_WAIT_CYCLES);

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_step_n   = r_step;
        w_mode_n   = r_mode;
        w_init_n   = r_init;
        w_en_n     = r_en;
        w_rs_n     = r_rs;
        w_done_n   = r_done;
        w_data_n   = r_data;
        w_result_n = r_result;
        if (clk_en) begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_mode_n = datab[1:0];
                        w_cnt_n  = '0;
                        unique case (datab[1:0])
                            2'b00, 2'b01: begin
                                w_rs_n    = datab[0];
                                w_data_n  = dataa[7:0];
                                w_state_n = SETUP;
                            end
                            2'b10: begin
                                w_step_n  = 2'd0;
                                w_state_n = PWRUP;
                            end
                            default: begin
                                // Status passes through NEXT so done
                                // lands one edge after start.
                                w_result_n = {31'b0, r_init};
                                w_state_n  = NEXT;
                            end
                        endcase
                    end
                end
                PWRUP: begin
                    if (r_cnt == last(POWERUP_CYCLES)) begin
                        w_cnt_n   = '0;
                        w_rs_n    = 1'b0;
                        w_data_n  = init_byte(2'd0);
                        w_state_n = SETUP;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                SETUP: begin
                    if (r_cnt == last(SETUP_CYCLES)) begin
                        w_cnt_n   = '0;
                        w_en_n    = 1'b1;
                        w_state_n = PULSE;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                PULSE: begin
                    if (r_cnt == last(EN_PULSE_CYCLES)) begin
                        w_cnt_n   = '0;
                        w_en_n    = 1'b0;
                        w_state_n = HOLD;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (r_cnt == last(HOLD_CYCLES)) begin
                        w_cnt_n   = '0;
                        w_state_n = WAIT;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        w_cnt_n = '0;
                        if (r_mode == 2'b10) begin
                            w_state_n = NEXT;
                        end else begin
                            w_done_n   = 1'b1;
                            w_result_n = '0;
                            w_state_n  = FINISH;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (r_mode == 2'b11) begin
                        w_done_n  = 1'b1;
                        w_state_n = FINISH;
                    end else if (r_step == 2'd3) begin
                        w_init_n   = 1'b1;
                        w_done_n   = 1'b1;
                        w_result_n = '0;
                        w_state_n  = FINISH;
                    end else begin
                        w_step_n  = r_step + 2'd1;
                        w_rs_n    = 1'b0;
                        w_data_n  = init_byte(r_step + 2'd1);
                        w_state_n = SETUP;
                    end
                end
                FINISH: begin
                    w_done_n  = 1'b0;
                    w_state_n = IDLE;
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_step   <= '0;
            r_mode   <= '0;
            r_init   <= 1'b0;
            r_en     <= 1'b0;
            r_rs     <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_step   <= w_step_n;
            r_mode   <= w_mode_n;
            r_init   <= w_init_n;
            r_en     <= w_en_n;
            r_rs     <= w_rs_n;
            r_done   <= w_done_n;
            r_data   <= w_data_n;
            r_result <= w_result_n;
        end
    end

    assign result     = r_result;
    assign done       = r_done;
    assign lcd_enable = r_en;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = r_data;
    assign w_unused   = ^{dataa[31:8], datab[31:2]};

endmodule

// File: tb/tb_lcd_ci_sequencer.sv
// tb_lcd_ci_sequencer: directed + randomized check of lcd_ci_sequencer
// against an edge-count timing model derived from the LCD write rules.
module tb_lcd_ci_sequencer;

    localparam int S  = 1;
    localparam int P  = 2;
    localparam int H  = 1;
    localparam int CM = 4;
    localparam int CL = 10;
    localparam int PW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done, lcd_enable, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;

    int n_cmp = 0;
    int n_bad = 0;
    bit m_init = 1'b0;

    lcd_ci_sequencer #(
        .SETUP_CYCLES(S), .EN_PULSE_CYCLES(P), .HOLD_CYCLES(H),
        .CMD_WAIT_CYCLES(CM), .CLEAR_WAIT_CYCLES(CL),
        .POWERUP_CYCLES(PW)
    ) dut (
        .clk(clk), .reset(rst), .clk_en(clk_en), .start(start),
        .dataa(dataa), .datab(datab), .result(result), .done(done),
        .lcd_enable(lcd_enable), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Execution wait chosen by the LCD rules: clear/home commands are long.
    function automatic int wlen(input logic rs, input logic [7:0] b);
        return (!rs && (b == 8'h01 || b == 8'h02)) ? CL : CM;
    endfunction

    // gmode: 0 clk_en always 1, 1 random clk_en, 2 three-cycle gap in PULSE
    task automatic run_op(input logic [1:0] md, input logic [7:0] b,
                          input int gmode, input bit poke);
        int k, c, dn_cnt, dn_rise, dn_fall, dn_cyc, en_cyc, post, gated;
        int base;
        logic [31:0] res;
        bit prev_en, prev_dn, en_edge, poked;
        int rq[$];
        int fq[$];
        logic [7:0] dq[$];
        logic rsq[$];
        logic [7:0] seq [4];
        seq = '{8'h38, 8'h0C, 8'h01, 8'h06};
        k = -1; c = -1; dn_cnt = 0; dn_rise = -1; dn_fall = -1;
        dn_cyc = -1; en_cyc = 0; post = 0; gated = 0; res = 'x;
        prev_en = 1'b0; prev_dn = 1'b0; en_edge = 1'b1; poked = 1'b0;
        @(negedge clk);
        dataa = $urandom; dataa[7:0] = b;
        datab = $urandom; datab[1:0] = md;
        start = 1'b1; clk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 2000 && post < 4; t++) begin
            if (en_edge) k++;
            c++;
            if (lcd_enable && !prev_en) begin
                rq.push_back(k); dq.push_back(lcd_data);
                rsq.push_back(lcd_rs);
            end
            if (!lcd_enable && prev_en) fq.push_back(k);
            if (lcd_enable) en_cyc++;
            if (done && !prev_dn) begin
                dn_cnt++; dn_rise = k; dn_cyc = c; res = result;
            end
            if (!done && prev_dn) dn_fall = k;
            if (dn_cnt > 0 && !done) post++;
            prev_en = lcd_enable; prev_dn = done;
            start = 1'b0;
            if (poke && !poked && k == S) begin
                start = 1'b1; datab = $urandom; dataa = $urandom;
                poked = 1'b1;
            end
            clk_en = 1'b1;
            if (gmode == 1) clk_en = ($urandom_range(0, 3) != 0);
            if (gmode == 2 && k == S + 1 && gated < 3) begin
                clk_en = 1'b0; gated++;
            end
            en_edge = clk_en;
            @(negedge clk);
        end
        clk_en = 1'b1;
        chk("timeout", 32'(post >= 4), 1);
        chk("done_count", dn_cnt, 1);
        chk("done_len", dn_fall - dn_rise, 1);
        chk("rw", lcd_rw, 0);
        if (md[1] == 1'b0) begin
            chk("done_edge", dn_rise, S + P + H + wlen(md[0], b));
            chk("result_wr", res, 0);
            chk("pulses", rq.size(), 1);
            if (rq.size() > 0) begin
                chk("rise_edge", rq[0], S);
                chk("pulse_data", dq[0], b);
                chk("pulse_rs", rsq[0], md[0]);
            end
            if (fq.size() > 0) chk("fall_edge", fq[0], S + P);
            chk("data_after", lcd_data, b);
            chk("rs_after", lcd_rs, md[0]);
            if (gmode != 1) begin
                chk("en_cycles", en_cyc, P + (gmode == 2 ? 3 : 0));
                chk("done_cyc", dn_cyc, dn_rise + (gmode == 2 ? 3 : 0));
            end
        end else if (md == 2'b10) begin
            base = PW;
            chk("init_pulses", rq.size(), 4);
            for (int j = 0; j < 4; j++) begin
                if (j < rq.size()) begin
                    chk("init_rise", rq[j], base + S);
                    chk("init_data", dq[j], seq[j]);
                    chk("init_rs", rsq[j], 0);
                end
                if (j < fq.size()) chk("init_fall", fq[j], base + S + P);
                base += S + P + H + wlen(1'b0, seq[j]) + 1;
            end
            chk("init_done_edge", dn_rise, base);
            chk("result_init", res, 0);
            m_init = 1'b1;
        end else begin
            chk("status_edge", dn_rise, 1);
            chk("status_result", res, {31'b0, m_init});
            chk("status_pulses", rq.size(), 0);
        end
    endtask

    initial begin
        int dn_seen;
        logic [1:0] md;
        logic [7:0] b;
        int r;
        #1;
        chk("rst_enable", lcd_enable, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_rw", lcd_rw, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 8'h80, 0, 1'b0);
        run_op(2'b01, 8'h41, 0, 1'b0);
        run_op(2'b00, 8'h01, 0, 1'b0);
        run_op(2'b11, 8'h00, 0, 1'b0);
        run_op(2'b10, 8'h00, 0, 1'b0);
        run_op(2'b11, 8'h00, 0, 1'b0);
        run_op(2'b01, 8'h5A, 2, 1'b0);
        run_op(2'b00, 8'h02, 0, 1'b1);
        run_op(2'b01, 8'h33, 0, 1'b1);

        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 9);
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 2));
            if (r <= 3) md = 2'b00;
            else if (r <= 6) md = 2'b01;
            else if (r == 7) md = 2'b10;
            else md = 2'b11;
            run_op(md, b, $urandom_range(0, 1), 1'(r == 5));
        end

        // Abort an init while its first write sits in WAIT.
        run_op(2'b10, 8'h00, 0, 1'b0);
        @(negedge clk);
        datab = 32'h2; dataa = $urandom; start = 1'b1; clk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (PW + S + P + H + 2) @(negedge clk);
        chk("pre_abort_data", lcd_data, 8'h38);
        #2 rst = 1'b1;
        #1;
        chk("abort_enable", lcd_enable, 0);
        chk("abort_rs", lcd_rs, 0);
        chk("abort_data", lcd_data, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        m_init = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dn_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dn_seen++;
        end
        chk("abort_no_done", dn_seen, 0);
        run_op(2'b11, 8'h00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_ci_sequencer.md
Name: lcd_ci_sequencer

Overview:
- Nios II multi-cycle custom instruction that drives an HD44780-compatible character LCD over an 8-bit parallel bus.
- Successor to the fixed three-command LCD initialiser. It adds:
  - parametrised enable, setup, hold and execution timing;
  - arbitrary command and data writes;
  - a repeatable init sequence;
  - a status read.
- Sits between the custom-instruction slot and the LCD pins.

Parameters:
- SETUP_CYCLES, 2: cycles rs/data are stable before lcd_enable rises.
- EN_PULSE_CYCLES, 25: lcd_enable high width (500 ns at 50 MHz).
- HOLD_CYCLES, 2: cycles rs/data are held after lcd_enable falls.
- CMD_WAIT_CYCLES, 2000: execution wait for normal command/data (40 us).
- CLEAR_WAIT_CYCLES, 82000: execution wait for commands 8'h01 and 8'h02.
- POWERUP_CYCLES, 750000: wait before the first init command (15 ms).
- INIT_FUNC, 8'h38: function-set byte used by init.
- INIT_DISP, 8'h0C: display-control byte used by init.
- INIT_ENTRY, 8'h06: entry-mode byte used by init.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  custom-instruction clock enable; FSM and counters advance only when high.
- start  in  1  one-cycle instruction start, qualified by clk_en.
- dataa  in  32  operand; [7:0] is the byte to write.
- datab  in  32  operand; [1:0] is the mode: 00 command, 01 data, 10 init, 11 status.
- result  out  32  instruction result, valid while done=1.
- done  out  1  one-cycle completion pulse.
- lcd_enable  out  1  LCD E.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  tied to 0 (write only).
- lcd_data  out  8  LCD DB[7:0].

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - lcd_enable=0, lcd_rs=0, lcd_data=0, done=0, result=0.
  - initialized flag cleared; FSM to IDLE; no done is produced for the aborted instruction.
- States: IDLE, PWRUP, SETUP, PULSE, HOLD, WAIT, NEXT, FINISH.
- Edge counting:
  - "Edge" means a rising clk edge with clk_en=1.
  - With clk_en=0, all state, counters and outputs hold.
- IDLE: start=1 on edge E0 latches the mode and byte.
  - Mode 00/01: lcd_rs <= mode[0], lcd_data <= dataa[7:0], go to SETUP.
  - Mode 10: go to PWRUP, step index = 0.
  - Mode 11: go to FINISH with result = {31'b0, initialized}.
- Single write timing, counted in edges after E0:
  - lcd_enable registers 1 at edge S and 0 at edge S+P.
  - done registers 1 at edge S+P+H+W for exactly one cycle, with result = 0.
  - S=SETUP_CYCLES, P=EN_PULSE_CYCLES, H=HOLD_CYCLES.
  - W=CLEAR_WAIT_CYCLES if the byte is 8'h01/8'h02 with rs=0, else CMD_WAIT_CYCLES.
- lcd_rs and lcd_data:
  - Stable from their load until HOLD and WAIT complete.
  - Unchanged after completion; they are not cleared.
- Init (mode 10):
  - PWRUP waits POWERUP_CYCLES edges.
  - Then four command writes (rs=0), each with full SETUP/PULSE/HOLD/WAIT: INIT_FUNC, INIT_DISP, 8'h01 (clear wait), INIT_ENTRY.
  - NEXT advances the step index; after the fourth write, initialized=1 and done pulses with result = 0.
  - Init may be re-issued at any time from IDLE.
- FINISH: done=1 for one cycle, then IDLE.
  - Mode 11 completes with done at E0+1.
- done is never asserted outside FINISH.
- start asserted while not in IDLE is ignored.
- Writes before init are permitted and executed normally.
- Counter widths are derived with $clog2 of the largest wait parameter.
- Zero parameter values are illegal. Minimum is 1 for every timing parameter.

Test Plan (bench overrides S=1, P=2, H=1, CMD_WAIT=4, CLEAR_WAIT=10, POWERUP=5; clk_en=1 unless stated):
- Reset, then mode 00 with dataa=8'h80 -> lcd_rs=0 and lcd_data=8'h80 after E0; enable high edges E1..E3 (two cycles); done one cycle at E8, result=0.
- Mode 01 with dataa=8'h41 -> lcd_rs=1 and lcd_data=8'h41; same timing; done at E8.
- Mode 00 with 8'h01 -> done at E14 (clear wait applied).
- Mode 11 before init returns result=0. Mode 10 then produces:
  - exactly four enable pulses with data 38,0C,01,06 and rs=0;
  - first enable edge at E5+1;
  - a single done at the end.
  A following mode 11 returns result=1.
- clk_en=0 for 3 cycles mid-PULSE -> enable high width extends by 3 cycles; done delayed by 3; no other change.
- Assert reset during WAIT of init -> all outputs 0 immediately; no done; next mode 11 returns 0.
- start pulsed again during PULSE -> ignored; exactly one done.
